// File: rtl/jk_ff.sv
// jk_ff: WIDTH independent JK flip-flops sharing one clock and one
// asynchronous active-low reset. Each bit decodes its (j,k) pair as
// hold / clear / set / toggle on the rising clock edge. qb is the
// combinational inverse of q and holds no state of its own.
module jk_ff #(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    input  logic             rst
);

    logic [WIDTH-1:0] r_q;

    // Per-bit JK update; reset forces RESET_VAL immediately and masks j/k.
    // An unknown j/k pair falls through to the default arm so X propagates
    // into q instead of being silently resolved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= RESET_VAL;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                case ({j[i], k[i]})
                    2'b00:   r_q[i] <= r_q[i];
                    2'b01:   r_q[i] <= 1'b0;
                    2'b10:   r_q[i] <= 1'b1;
                    2'b11:   r_q[i] <= ~r_q[i];
                    default: r_q[i] <= 1'bx;
                endcase
            end
        end
    end

    // Outputs are taken straight from the state; qb tracks q at all times.
    assign q  = r_q;
    assign qb = ~r_q;

endmodule

// File: tb/tb_jk_ff.sv
module tb_jk_ff;

    logic       clk = 1'b0;
    logic       rst1, rst4;
    logic       j1, k1;
    logic [3:0] j4, k4;
    logic       q1, qb1;
    logic [3:0] q4, qb4;

    int errors = 0;
    int checks = 0;

    logic       m1;
    logic [3:0] m4;
    bit         m4_valid = 1'b0;

    localparam logic [3:0] RV4 = 4'b1010;

    always #5 clk = ~clk;

    jk_ff u1 (.q(q1), .qb(qb1), .j(j1), .k(k1), .clk(clk), .rst(rst1));
    jk_ff #(.WIDTH(4), .RESET_VAL(4'b1010)) u4 (
        .q(q4), .qb(qb4), .j(j4), .k(k4), .clk(clk), .rst(rst4));

    // Reference behaviour of one JK bit, straight from the truth table.
    function automatic logic jk_next(input logic qo, input logic jj, input logic kk);
        if (jj && kk) return !qo;
        if (jj)       return 1'b1;
        if (kk)       return 1'b0;
        return qo;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance models at the rising edge,
    // compare both instances just after it, then confirm the falling edge
    // leaves q untouched. Returns at the falling edge.
    task automatic cyc(input logic jj1, input logic kk1,
                       input logic [3:0] jj4, input logic [3:0] kk4);
        logic       eqb1;
        logic [3:0] eqb4;
        j1 = jj1; k1 = kk1; j4 = jj4; k4 = kk4;
        @(posedge clk);
        #1;
        if (!rst1) m1 = 1'b0;
        else       m1 = jk_next(m1, jj1, kk1);
        if (!rst4) begin
            m4 = RV4;
            m4_valid = 1'b1;
        end else if (m4_valid) begin
            for (int b = 0; b < 4; b++) m4[b] = jk_next(m4[b], jj4[b], kk4[b]);
        end
        eqb1 = !m1;
        check("q1", {3'b0, q1}, {3'b0, m1});
        check("qb1", {3'b0, qb1}, {3'b0, eqb1});
        if (m4_valid) begin
            eqb4 = ~m4;
            check("q4", q4, m4);
            check("qb4", qb4, eqb4);
        end
        @(negedge clk);
        #1;
        check("q1_negedge_hold", {3'b0, q1}, {3'b0, m1});
    endtask

    logic seq_j [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic seq_k [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic seq_q [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic tog_q [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst1 = 1'b1; rst4 = 1'b1;
        j1 = 1'b1; k1 = 1'b0; j4 = 4'b0; k4 = 4'b0;
        m1 = 1'b0;
        m4 = 4'b0;

        // Wide instance: async reset loads RESET_VAL without a clock edge.
        #2 rst4 = 1'b0;
        #1;
        check("w4_reset_q", q4, 4'b1010);
        check("w4_reset_qb", qb4, 4'b0101);
        m4 = RV4;
        m4_valid = 1'b1;

        // Directed truth-table walk on the 1-bit instance, no reset.
        for (int s = 0; s < 8; s++) begin
            cyc(seq_j[s], seq_k[s], 4'b0011, 4'b0101);
            check("seq_q", {3'b0, q1}, {3'b0, seq_q[s]});
        end

        // Wide instance release, then one mixed edge.
        rst4 = 1'b1;
        #1 check("w4_release_no_change", q4, 4'b1010);
        cyc(1'b0, 1'b0, 4'b0011, 4'b0101);
        check("w4_mixed_edge", q4, 4'b1011);

        // Async reset asserted mid-cycle with q=1.
        #2 rst1 = 1'b0;
        #1;
        check("async_q", {3'b0, q1}, 4'b0000);
        check("async_qb", {3'b0, qb1}, 4'b0001);
        m1 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
            check("held_in_reset", {3'b0, q1}, 4'b0000);
        end

        // Release between edges: nothing changes until the next rising edge.
        rst1 = 1'b1;
        j1 = 1'b1; k1 = 1'b0;
        #2 check("release_not_early", {3'b0, q1}, 4'b0000);
        cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
        check("release_first_edge", {3'b0, q1}, 4'b0001);

        // Reset pulse then four toggles.
        #1 rst1 = 1'b0;
        #1 rst1 = 1'b1;
        m1 = 1'b0;
        for (int s = 0; s < 4; s++) begin
            cyc(1'b1, 1'b1, 4'b0000, 4'b0000);
            check("toggle_seq", {3'b0, q1}, {3'b0, tog_q[s]});
        end

        // Reset asserted while a toggle is pending overrides it.
        j1 = 1'b1; k1 = 1'b1;
        #2 rst1 = 1'b0;
        cyc(1'b1, 1'b1, 4'b0000, 4'b0000);
        check("reset_overrides_toggle", {3'b0, q1}, 4'b0000);
        rst1 = 1'b1;

        // j/k wiggling between edges has no effect; only the last value counts.
        cyc(1'b1, 1'b0, 4'b0000, 4'b0000);
        j1 = 1'b0; k1 = 1'b1;
        #2 j1 = 1'b1; k1 = 1'b1;
        #1 check("midcycle_jk_ignored", {3'b0, q1}, 4'b0001);

        // Randomised traffic with occasional resets on either instance.
        for (int n = 0; n < 300; n++) begin
            logic       rj1, rk1;
            logic [3:0] rj4, rk4;
            rj1 = 1'($urandom); rk1 = 1'($urandom);
            rj4 = 4'($urandom); rk4 = 4'($urandom);
            rst1 = ($urandom_range(0, 15) != 0);
            rst4 = ($urandom_range(0, 15) != 0);
            #1;
            if (!rst1) check("rand_async_q1", {3'b0, q1}, 4'b0000);
            if (!rst4) check("rand_async_q4", q4, RV4);
            cyc(rj1, rk1, rj4, rk4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_ff.md
JK_FF -- requirements
Module: jk_ff

Interface
REQ-001 Parameter WIDTH, default 1: number of independent JK bits; each bit of j/k/q/qb is one flop.
REQ-002 Parameter RESET_VAL, default all-zero (WIDTH bits): value loaded into q while reset is asserted.
REQ-003 clk  input  1  single clock; all state changes occur on its rising edge, except reset.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 = reset asserted, 1 = normal operation.
REQ-005 j  input  WIDTH  per-bit set/toggle request, sampled at rising clk.
REQ-006 k  input  WIDTH  per-bit clear/toggle request, sampled at rising clk.
REQ-007 q  output  WIDTH  registered flop state.
REQ-008 qb  output  WIDTH  complement of q.
REQ-009 Positional port order SHALL be q, qb, j, k, clk, rst, so that positional instantiation jk_ff(q, qb, j, k, clk, rst) connects correctly.

Function
REQ-010 On each rising clk edge with rst=1, each bit i SHALL update q[i] per the (j[i],k[i]) pair below; all bits update independently in the same edge.
REQ-011 j=0,k=0: hold; q[i] keeps its previous value.
REQ-012 j=0,k=1: reset; q[i] becomes 0.
REQ-013 j=1,k=0: set; q[i] becomes 1.
REQ-014 j=1,k=1: toggle; q[i] becomes the inverse of its previous value, once per rising edge (no race or oscillation within a cycle).
REQ-015 Latency: the new q SHALL be visible immediately after the rising edge that samples j/k; there is no further pipeline delay.
REQ-016 j/k changes between rising edges SHALL have no effect on q; falling edges SHALL have no effect.
REQ-017 qb SHALL equal the bitwise inverse of q at all times, including during and after reset; it is derived combinationally from q and holds no separate state.
REQ-018 j or k at X/Z SHALL make the corresponding q bit X after the edge (simulation only; no masking).
REQ-019 Before the first reset or the first set/reset edge, q is unspecified; no power-up initialisation is required. After the first edge with j=1,k=0 or j=0,k=1, q SHALL be defined even if rst was never asserted.

Reset
REQ-020 When rst falls to 0, q SHALL take the value RESET_VAL immediately, without waiting for a clk edge; qb SHALL take the inverse of RESET_VAL.
REQ-021 While rst=0, clk edges and j/k SHALL be ignored, and q SHALL remain RESET_VAL.
REQ-022 When rst rises to 1, the first state change SHALL occur at the next rising clk edge. If rst rises in the same timestep as a clk rising edge, reset wins for that edge.
REQ-023 Assertion of rst mid-toggle or mid-sequence SHALL override any pending j/k action.

Verification
REQ-024 Setup: 10-unit clock, rising edges at t=5,15,25,...; rst=1 throughout; j/k changed at t=0,10,20,30,40,50 to (1,0),(0,0),(0,1),(1,0),(1,1),(1,0). Required q after each edge: t=5 -> 1, t=15 -> 1 (hold), t=25 -> 0, t=35 -> 1, t=45 -> 0 (toggle), t=55 -> 1, t=65 and t=75 -> 1. qb SHALL be the inverse of q after every edge.
REQ-025 Async reset: with q=1, drive rst=0 mid-cycle (not at an edge) -> q=0 and qb=1 before the next clk edge; hold j=1,k=0 for 3 edges -> q stays 0.
REQ-026 Reset release: rst 0->1, then j=1,k=0 -> q=1 at the first rising edge after release and not earlier.
REQ-027 Repeated toggle: after reset, j=k=1 for 4 edges -> q sequence 1,0,1,0; qb always complementary.
REQ-028 WIDTH=4, RESET_VAL=4'b1010: assert reset -> q=1010; then j=0011,k=0101 for one edge -> q=1011 (bit0 toggle, bit1 set, bit2 clear, bit3 hold).
